// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared state encoding, color decode and per-level display timing
package genius_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHOW_ON,
      ST_SHOW_OFF,
      ST_WAIT_IN,
      ST_NEXT,
      ST_WIN,
      ST_LOSE
   } state_t;

   localparam int TIMER_W = 8;

   function automatic logic [3:0] color_decode(input logic [1:0] color);
      return 4'b0001 << color;
   endfunction

   // Higher levels flash each color for fewer ticks.
   function automatic logic [TIMER_W-1:0] on_ticks(input logic [1:0] level);
      case (level)
         2'd2:    return TIMER_W'(3);
         2'd3:    return TIMER_W'(2);
         default: return TIMER_W'(4);
      endcase
   endfunction

endpackage

// File: rtl/genius_tick_timer.sv
// rtl/genius_tick_timer.sv - loadable TICK down-counter flagging the final counted tick
module genius_tick_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Load wins over tick, so a tick in the reload cycle is not counted.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (tick && cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign expired = tick && (cnt == W'(1));

endmodule

// File: rtl/genius_round_ctrl.sv
// rtl/genius_round_ctrl.sv - Genius round sequencer: replay sequence, check presses, track rounds
module genius_round_ctrl
   import genius_pkg::*;
#(
   parameter int MAX_ROUND     = 15,
   parameter int TIMEOUT_TICKS = 8,
   parameter int OFF_TICKS     = 1
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       START,
   input  logic       TICK,
   input  logic [1:0] REG_SetupLEVEL,
   input  logic [3:0] BTN,
   input  logic [1:0] SEQ_DATA,
   output logic [3:0] SEQ_ADDR,
   output logic [3:0] LED,
   output logic [3:0] ROUND,
   output logic [1:0] LEVEL,
   output logic       BUSY,
   output logic       WAITING,
   output logic       WIN,
   output logic       LOSE
);

   localparam logic [3:0] MAX_R = 4'(MAX_ROUND);

   state_t             state, state_nxt;
   logic [3:0]         addr_q, addr_nxt;
   logic [3:0]         round_q, round_nxt;
   logic [1:0]         level_q, level_nxt;
   logic               rearm;
   logic               tmr_load, tmr_clr, tmr_expired;
   logic [TIMER_W-1:0] tmr_val;
   logic [3:0]         exp_color;
   logic               btn_onehot;

   assign exp_color  = color_decode(SEQ_DATA);
   assign btn_onehot = (BTN != 4'd0) && ((BTN & (BTN - 4'd1)) == 4'd0);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         round_q <= '0;
         level_q <= '0;
      end else begin
         state   <= state_nxt;
         addr_q  <= addr_nxt;
         round_q <= round_nxt;
         level_q <= level_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_q;
      round_nxt = round_q;
      level_nxt = level_q;
      rearm     = 1'b0;
      case (state)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (START) begin
               level_nxt = REG_SetupLEVEL;
               round_nxt = '0;
               addr_nxt  = '0;
               state_nxt = ST_SHOW_ON;
            end
         end
         ST_SHOW_ON: begin
            if (tmr_expired)
               state_nxt = ST_SHOW_OFF;
         end
         ST_SHOW_OFF: begin
            if (tmr_expired) begin
               if (addr_q == round_q) begin
                  addr_nxt  = '0;
                  state_nxt = ST_WAIT_IN;
               end else begin
                  addr_nxt  = addr_q + 4'd1;
                  state_nxt = ST_SHOW_ON;
               end
            end
         end
         ST_WAIT_IN: begin
            // A press is decided before the timeout, so it wins a same-cycle tie.
            if (BTN != 4'd0) begin
               if (!btn_onehot || BTN != exp_color)
                  state_nxt = ST_LOSE;
               else if (addr_q == round_q)
                  state_nxt = ST_NEXT;
               else begin
                  addr_nxt = addr_q + 4'd1;
                  rearm    = 1'b1;
               end
            end else if (tmr_expired) begin
               state_nxt = ST_LOSE;
            end
         end
         ST_NEXT: begin
            round_nxt = round_q + 4'd1;
            if (round_q + 4'd1 == MAX_R)
               state_nxt = ST_WIN;
            else begin
               addr_nxt  = '0;
               state_nxt = ST_SHOW_ON;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Timer is reloaded on every state change and on each accepted intermediate press.
   always_comb begin
      tmr_load = 1'b0;
      tmr_clr  = 1'b0;
      tmr_val  = '0;
      if (state_nxt != state || rearm) begin
         case (state_nxt)
            ST_SHOW_ON: begin
               tmr_load = 1'b1;
               tmr_val  = on_ticks(level_nxt);
            end
            ST_SHOW_OFF: begin
               tmr_load = 1'b1;
               tmr_val  = TIMER_W'(OFF_TICKS);
            end
            ST_WAIT_IN: begin
               tmr_load = 1'b1;
               tmr_val  = TIMER_W'(TIMEOUT_TICKS);
            end
            default: tmr_clr = 1'b1;
         endcase
      end
   end

   genius_tick_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk      (CLOCK),
      .rst      (RESET),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tick     (TICK),
      .expired  (tmr_expired)
   );

   always_comb begin
      LED = 4'd0;
      case (state)
         ST_SHOW_ON: LED = exp_color;
         ST_WIN:     LED = 4'b1111;
         default:    LED = 4'd0;
      endcase
   end

   assign SEQ_ADDR = addr_q;
   assign ROUND    = round_q;
   assign LEVEL    = level_q;
   assign BUSY     = !(state == ST_IDLE || state == ST_WIN || state == ST_LOSE);
   assign WAITING  = (state == ST_WAIT_IN);
   assign WIN      = (state == ST_WIN);
   assign LOSE     = (state == ST_LOSE);

endmodule

// File: doc/genius_round_ctrl.md
Name: genius_round_ctrl

Overview:
- Round sequencer for the Genius (Simon) game.
- Each round it plays the color sequence from the sequence memory on the LEDs, then checks the player's button presses against that sequence.
- It advances or ends the game and drives the completed-round count and latched level to the scoring logic (points = level × rounds).
- Sits between setup registers, button debouncers, the sequence memory and the scoring block.

Parameters:
- MAX_ROUND, 15, completed rounds needed to win (1..15).
- TIMEOUT_TICKS, 8, TICK pulses allowed between presses in WAIT_IN before loss.
- OFF_TICKS, 1, TICK pulses of dark gap after each displayed color.

Ports:
- CLOCK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse; starts a new game from IDLE, WIN or LOSE.
- TICK  in  1  single-cycle timebase pulse; all durations are counted in TICKs.
- REG_SetupLEVEL  in  2  game level; sampled only on an accepted START.
- BTN  in  4  one-hot color button pulses, debounced, one cycle each.
- SEQ_DATA  in  2  color at SEQ_ADDR; combinational, valid in the same cycle.
- SEQ_ADDR  out  4  sequence step index.
- LED  out  4  one-hot color display.
- ROUND  out  4  completed rounds; goes to scoring.
- LEVEL  out  2  level latched at START; goes to scoring.
- BUSY  out  1  high in any state except IDLE, WIN, LOSE.
- WAITING  out  1  high in WAIT_IN.
- WIN  out  1  high while in WIN state.
- LOSE  out  1  high while in LOSE state.

Behaviour:
- Reset values: state=IDLE; SEQ_ADDR=0, LED=0, ROUND=0, LEVEL=0; BUSY, WAITING, WIN, LOSE all 0; all counters 0.
- RESET has priority over every other input, including a START in the same cycle, and aborts any state.
- Color encoding: SEQ_DATA 0..3 maps to LED = 1<<SEQ_DATA.
- ON_TICKS per latched level: 0 → 4, 1 → 4, 2 → 3, 3 → 2.
- LEVEL keeps its latched value even when REG_SetupLEVEL is 0; scoring then yields 0 points.
- Current round length is ROUND+1 steps.
- IDLE:
  - All outputs idle.
  - START → latch LEVEL, ROUND=0, SEQ_ADDR=0, go to SHOW_ON.
- SHOW_ON:
  - LED = decode(SEQ_DATA).
  - After ON_TICKS TICKs → SHOW_OFF.
- SHOW_OFF:
  - LED=0.
  - After OFF_TICKS TICKs:
    - if SEQ_ADDR == ROUND → SEQ_ADDR=0, clear timeout counter, go to WAIT_IN;
    - else SEQ_ADDR+1, go to SHOW_ON.
- BTN pulses outside WAIT_IN are ignored and are not queued.
- WAIT_IN:
  - LED=0, WAITING=1.
  - BTN ≠ 0 → evaluated in the same cycle:
    - BTN not one-hot (two or more bits set) → LOSE.
    - BTN ≠ decode(SEQ_DATA) → LOSE.
    - Match and SEQ_ADDR < ROUND → SEQ_ADDR+1, clear timeout counter, stay in WAIT_IN.
    - Match and SEQ_ADDR == ROUND → NEXT.
  - Each TICK with no press increments the timeout counter.
  - Timeout counter reaching TIMEOUT_TICKS → LOSE.
  - A press and the final timeout TICK in the same cycle: the press wins.
- NEXT (one cycle):
  - ROUND+1.
  - If the new ROUND == MAX_ROUND → WIN.
  - Otherwise SEQ_ADDR=0 → SHOW_ON.
- WIN / LOSE:
  - ROUND and LEVEL are held so the score stays visible.
  - LED=4'b1111 in WIN, 0 in LOSE.
  - START → same action as from IDLE.
- START while BUSY is ignored.
- TICK counters clear on every state entry.
- A TICK arriving in the cycle of state entry is not counted.
- ROUND never exceeds MAX_ROUND and never wraps.
- Latency: a press decision is registered and the new state is visible the cycle after the press.

Decomposition:
- Shared package genius_pkg:
  - state enum (IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, NEXT, WIN, LOSE);
  - color-decode function;
  - ON_TICKS lookup per level.
- One sub-module, genius_tick_timer:
  - loadable TICK down-counter with clear and expired flag;
  - shared by the show and timeout phases.
- Everything else stays in the FSM.

Test Plan:
- Reset mid-SHOW_ON with START asserted in the same cycle → next cycle IDLE; LED=0, ROUND=0, SEQ_ADDR=0, BUSY=0.
- START with REG_SetupLEVEL=2, SEQ_DATA for step0=1 → LED=4'b0010 for exactly 3 TICKs, then 0 for 1 TICK, then WAITING=1; LEVEL=2.
- Round 0, press BTN=4'b0010 → ROUND=1, two-step replay begins. A further correct two-press reply → ROUND=2; scoring shows 4.
- In WAIT_IN press BTN=4'b0011 → LOSE=1; ROUND holds the prior value.
- In WAIT_IN, supply 8 TICKs with no press (TIMEOUT_TICKS=8) → LOSE on the 8th. Repeat with a correct press in the same cycle as the 8th TICK → no LOSE.
- MAX_ROUND=2 with all replies correct → WIN=1, LED=4'b1111, ROUND=2. START then restarts with ROUND=0 and the new level latched.
